// File: rtl/jtframe_i2s_seq.sv
// I2S DAC sequencer: double-buffers 16-bit stereo samples and serializes them in
// Philips I2S framing (64 BCLK per frame). Optional 6 dB attenuation: JTFRAME_I2S_ATT_EN.
module jtframe_i2s_seq #(
   parameter int CLKDIV     = 8,
   parameter int SIGNED_SND = 1
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] snd_left,
   input  logic [15:0] snd_right,
   input  logic        sample,
   output logic        i2s_bclk,
   output logic        i2s_lrclk,
   output logic        i2s_data,
   output logic        underrun,
   output logic [7:0]  underrun_cnt,
   output logic        running
);

   localparam int             CW      = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
   localparam logic [CW-1:0]  CNT_MAX = CW'(CLKDIV - 1);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t        state, state_next;
   logic [CW-1:0] cnt, cnt_next;
   logic          bclk, bclk_next;
   logic          lrclk, lrclk_next;
   logic          data, data_next;
   logic [5:0]    bitn, bitn_next, bit_adv;
   logic [4:0]    idx;
   logic [31:0]   shift, shift_next;
   logic [15:0]   hold_l, hold_l_next;
   logic [15:0]   hold_r, hold_r_next;
   logic          fresh, fresh_next;
   logic          urun, urun_next;
   logic [7:0]    ucnt, ucnt_next;
   logic          run, run_next;

   // Format conversion applied once, when the sample enters the holding stage
   function automatic logic [15:0] conv(input logic [15:0] x);
      logic [15:0] y;
      y = (SIGNED_SND != 0) ? x : {~x[15], x[14:0]};
`ifdef JTFRAME_I2S_ATT_EN
      y = {y[15], y[15:1]};
`endif
      return y;
   endfunction

   always_comb begin
      state_next  = state;
      cnt_next    = cnt;
      bclk_next   = bclk;
      lrclk_next  = lrclk;
      data_next   = data;
      bitn_next   = bitn;
      shift_next  = shift;
      hold_l_next = hold_l;
      hold_r_next = hold_r;
      fresh_next  = fresh;
      urun_next   = 1'b0;
      ucnt_next   = ucnt;
      bit_adv     = bitn + 6'd1;
      idx         = 5'd16 - bit_adv[4:0];

      if (sample) begin
         hold_l_next = conv(snd_left);
         hold_r_next = conv(snd_right);
         fresh_next  = 1'b1;
      end

      case (state)
         IDLE: begin
            cnt_next   = '0;
            bclk_next  = 1'b0;
            lrclk_next = 1'b1;
            data_next  = 1'b0;
            bitn_next  = 6'd63;
            if (sample) state_next = RUN;
         end
         RUN: begin
            if (cnt == CNT_MAX) begin
               cnt_next  = '0;
               bclk_next = ~bclk;
               if (bclk) begin
                  bitn_next  = bit_adv;
                  lrclk_next = bit_adv[5];
                  data_next  = 1'b0;
                  if (bitn == 6'd63) begin
                     shift_next = {hold_l, hold_r};
                     if (!fresh) begin
                        urun_next = 1'b1;
                        if (ucnt != 8'hFF) ucnt_next = ucnt + 8'd1;
                     end
                     // a strobe landing on the frame start belongs to the next frame
                     fresh_next = sample;
                  end else if (bit_adv[4:0] >= 5'd1 && bit_adv[4:0] <= 5'd16) begin
                     // left slot reads the upper half of shift, right slot the lower half
                     data_next = shift[{~bit_adv[5], idx[3:0]}];
                  end
               end
            end else begin
               cnt_next = cnt + CW'(1);
            end
         end
         default: state_next = IDLE;
      endcase

      run_next = (state_next == RUN);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         bclk   <= 1'b0;
         lrclk  <= 1'b1;
         data   <= 1'b0;
         bitn   <= 6'd63;
         shift  <= '0;
         hold_l <= '0;
         hold_r <= '0;
         fresh  <= 1'b0;
         urun   <= 1'b0;
         ucnt   <= '0;
         run    <= 1'b0;
      end else begin
         state  <= state_next;
         cnt    <= cnt_next;
         bclk   <= bclk_next;
         lrclk  <= lrclk_next;
         data   <= data_next;
         bitn   <= bitn_next;
         shift  <= shift_next;
         hold_l <= hold_l_next;
         hold_r <= hold_r_next;
         fresh  <= fresh_next;
         urun   <= urun_next;
         ucnt   <= ucnt_next;
         run    <= run_next;
      end
   end

   assign i2s_bclk     = bclk;
   assign i2s_lrclk    = lrclk;
   assign i2s_data     = data;
   assign underrun     = urun;
   assign underrun_cnt = ucnt;
   assign running      = run;

endmodule

// File: tb/tb_jtframe_i2s_seq.sv
// Bench for jtframe_i2s_seq: lane 0 is CLKDIV=2 signed, lane 1 is CLKDIV=1 offset binary.
// A negedge monitor decodes each lane's I2S stream into frames for the checks.
`timescale 1ns/1ps
module tb_jtframe_i2s_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] snd_left = '0;
   logic [15:0] snd_right = '0;
   logic        sample = 1'b0;

   logic [1:0]  bclk_w, lrclk_w, data_w, urun_w, running_w;
   logic [7:0]  ucnt_w [2];

   int pass = 0;
   int total = 0;

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      jtframe_i2s_seq #(
         .CLKDIV     ((gi == 0) ? 2 : 1),
         .SIGNED_SND ((gi == 0) ? 1 : 0)
      ) dut (
         .clk          (clk),
         .rst_n        (rst_n),
         .snd_left     (snd_left),
         .snd_right    (snd_right),
         .sample       (sample),
         .i2s_bclk     (bclk_w[gi]),
         .i2s_lrclk    (lrclk_w[gi]),
         .i2s_data     (data_w[gi]),
         .underrun     (urun_w[gi]),
         .underrun_cnt (ucnt_w[gi]),
         .running      (running_w[gi])
      );
   end

   // ---------------- stream monitor ----------------
   int          pos [2];
   int          since [2];
   int          fcount [2];
   int          upulses [2];
   logic [15:0] cur_l [2];
   logic [15:0] cur_r [2];
   logic [15:0] fl [2];
   logic [15:0] fr [2];
   logic        cur_ok [2];
   logic        fok [2];
   logic        act [2];
   logic        seen [2];
   logic        prev_b [2];
   logic        prev_lr [2];

   function automatic int per_of(input int k);
      return (k == 0) ? 4 : 2;
   endfunction

   function automatic logic bit_ok(input int p, input logic lr, input logic d);
      logic slot;
      slot = (p >= 1 && p <= 16) || (p >= 33 && p <= 48);
      return (lr == (p >= 32)) && (slot || d == 1'b0);
   endfunction

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            act[k]     <= 1'b0;
            seen[k]    <= 1'b0;
            prev_b[k]  <= 1'b0;
            prev_lr[k] <= 1'b1;
            since[k]   <= 0;
         end else begin
            prev_b[k] <= bclk_w[k];
            since[k]  <= since[k] + 1;
            if (urun_w[k] === 1'b1) upulses[k] <= upulses[k] + 1;
            if (bclk_w[k] && !prev_b[k]) begin
               since[k]   <= 1;
               seen[k]    <= 1'b1;
               prev_lr[k] <= lrclk_w[k];
               if (!lrclk_w[k] && prev_lr[k]) begin
                  act[k]    <= 1'b1;
                  pos[k]    <= 0;
                  cur_l[k]  <= '0;
                  cur_r[k]  <= '0;
                  cur_ok[k] <= bit_ok(0, lrclk_w[k], data_w[k]) &&
                               (!seen[k] || since[k] == per_of(k));
               end else if (act[k]) begin
                  pos[k] <= pos[k] + 1;
                  if (pos[k] < 16) cur_l[k] <= {cur_l[k][14:0], data_w[k]};
                  if (pos[k] >= 32 && pos[k] < 48) cur_r[k] <= {cur_r[k][14:0], data_w[k]};
                  cur_ok[k] <= cur_ok[k] && bit_ok(pos[k] + 1, lrclk_w[k], data_w[k]) &&
                               (since[k] == per_of(k));
                  if (pos[k] == 62) begin
                     act[k]    <= 1'b0;
                     fl[k]     <= cur_l[k];
                     fr[k]     <= cur_r[k];
                     fok[k]    <= cur_ok[k] && bit_ok(63, lrclk_w[k], data_w[k]) &&
                                  (since[k] == per_of(k));
                     fcount[k] <= fcount[k] + 1;
                  end
               end
            end
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) $display("FAIL %s: got %0h want %0h", name, got, want);
      else pass++;
   endtask

   task automatic wait_count(input int k, input int target, input int budget);
      int n;
      n = 0;
      while (fcount[k] < target && n < budget) begin
         @(posedge clk);
         n++;
      end
      if (fcount[k] < target) begin
         total++;
         $display("FAIL wait_frame_lane%0d: got %0d frames want %0d", k, fcount[k], target);
      end
   endtask

   task automatic strobe(input logic [15:0] l, input logic [15:0] r);
      @(negedge clk);
      snd_left  = l;
      snd_right = r;
      sample    = 1'b1;
      @(negedge clk);
      sample    = 1'b0;
   endtask

   typedef struct {
      logic [15:0] l, r;
      logic [15:0] el0, er0;
      logic [15:0] el1, er1;
   } vec_t;

   vec_t tbl [4];

   initial begin
      int s0, s1, su, sc, n, bad;
      logic [15:0] e_2222, e_3333, e_6006, e_0990, e_5555, e_aaaa, e_sat_l, e_sat_r;

`ifdef JTFRAME_I2S_ATT_EN
      tbl[0] = '{16'hA5C3, 16'h0F01, 16'hD2E1, 16'h0780, 16'h12E1, 16'hC780};
      tbl[1] = '{16'h8000, 16'h7FFF, 16'hC000, 16'h3FFF, 16'h0000, 16'hFFFF};
      tbl[2] = '{16'h8002, 16'h0001, 16'hC001, 16'h0000, 16'h0001, 16'hC000};
      tbl[3] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'h3FFF, 16'hC000};
      e_2222 = 16'h1111; e_3333 = 16'h1999; e_6006 = 16'h3003; e_0990 = 16'h04C8;
      e_5555 = 16'h2AAA; e_aaaa = 16'hD555; e_sat_l = 16'hC91A; e_sat_r = 16'h15E6;
`else
      tbl[0] = '{16'hA5C3, 16'h0F01, 16'hA5C3, 16'h0F01, 16'h25C3, 16'h8F01};
      tbl[1] = '{16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF};
      tbl[2] = '{16'h8002, 16'h0001, 16'h8002, 16'h0001, 16'h0002, 16'h8001};
      tbl[3] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'h7FFF, 16'h8000};
      e_2222 = 16'h2222; e_3333 = 16'h3333; e_6006 = 16'h6006; e_0990 = 16'h0990;
      e_5555 = 16'h5555; e_aaaa = 16'hAAAA; e_sat_l = 16'h9234; e_sat_r = 16'h2BCD;
`endif

      // reset and idle
      repeat (4) @(negedge clk);
      chk("rst_bclk", 32'(bclk_w), 32'h0);
      chk("rst_lrclk", 32'(lrclk_w), 32'h3);
      chk("rst_data", 32'(data_w), 32'h0);
      chk("rst_underrun", 32'(urun_w), 32'h0);
      chk("rst_running", 32'(running_w), 32'h0);
      chk("rst_ucnt0", 32'(ucnt_w[0]), 32'h0);
      rst_n = 1'b1;
      bad = 0;
      repeat (1000) begin
         @(negedge clk);
         if (bclk_w != 2'b00 || lrclk_w != 2'b11 || data_w != 2'b00 ||
             running_w != 2'b00 || urun_w != 2'b00) bad++;
      end
      chk("idle_hold_cycles_bad", 32'(bad), 32'h0);

      // table-driven frames
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin
            wait_count(0, fcount[0] + 1, 600);
            repeat (20) @(negedge clk);
         end
         strobe(tbl[i].l, tbl[i].r);
         @(posedge clk);
         s0 = fcount[0];
         s1 = fcount[1];
         wait_count(1, s1 + 2, 600);
         chk($sformatf("vec%0d_lane1_L", i), 32'(fl[1]), 32'(tbl[i].el1));
         chk($sformatf("vec%0d_lane1_R", i), 32'(fr[1]), 32'(tbl[i].er1));
         chk($sformatf("vec%0d_lane1_fmt", i), 32'(fok[1]), 32'h1);
         wait_count(0, s0 + 2, 1200);
         chk($sformatf("vec%0d_lane0_L", i), 32'(fl[0]), 32'(tbl[i].el0));
         chk($sformatf("vec%0d_lane0_R", i), 32'(fr[0]), 32'(tbl[i].er0));
         chk($sformatf("vec%0d_lane0_fmt", i), 32'(fok[0]), 32'h1);
      end

      // two strobes in one frame: latest wins
      wait_count(0, fcount[0] + 1, 600);
      repeat (20) @(negedge clk);
      strobe(16'h1111, 16'h0000);
      repeat (40) @(negedge clk);
      strobe(16'h2222, 16'h3333);
      @(posedge clk);
      s0 = fcount[0];
      wait_count(0, s0 + 2, 1200);
      chk("overrun_L", 32'(fl[0]), 32'(e_2222));
      chk("overrun_R", 32'(fr[0]), 32'(e_3333));

      // returned one cycle after the last-bit BCLK rise: the next clk edge but one is the frame start
      su = upulses[0];
      sc = 32'(ucnt_w[0]);
      s0 = fcount[0];
      strobe(16'h6006, 16'h0990);
      wait_count(0, s0 + 1, 600);
      chk("collide_replay_L", 32'(fl[0]), 32'(e_2222));
      wait_count(0, s0 + 2, 600);
      chk("collide_next_L", 32'(fl[0]), 32'(e_6006));
      chk("collide_next_R", 32'(fr[0]), 32'(e_0990));
      chk("collide_upulses", 32'(upulses[0] - su), 32'h1);
      chk("collide_ucnt_step", 32'(32'(ucnt_w[0]) - sc), 32'h1);

      // reset in the middle of a frame
      n = 0;
      while (!(act[0] && pos[0] == 20) && n < 600) begin
         @(posedge clk);
         n++;
      end
      chk("reach_bitn20", 32'(pos[0]), 32'd20);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_bclk", 32'(bclk_w[0]), 32'h0);
      chk("midrst_lrclk", 32'(lrclk_w[0]), 32'h1);
      chk("midrst_data", 32'(data_w[0]), 32'h0);
      chk("midrst_running", 32'(running_w[0]), 32'h0);
      chk("midrst_ucnt0", 32'(ucnt_w[0]), 32'h0);
      chk("midrst_ucnt1", 32'(ucnt_w[1]), 32'h0);
      rst_n = 1'b1;
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (running_w != 2'b00 || bclk_w != 2'b00) bad++;
      end
      chk("post_rst_idle_bad", 32'(bad), 32'h0);

      // restart latency from IDLE
      su = upulses[0];
      s0 = fcount[0];
      @(negedge clk);
      snd_left  = 16'h5555;
      snd_right = 16'hAAAA;
      sample    = 1'b1;
      @(negedge clk);
      sample    = 1'b0;
      chk("start_running", 32'(running_w[0]), 32'h1);
      chk("start_bclk_c0", 32'(bclk_w[0]), 32'h0);
      @(negedge clk);
      chk("start_bclk_c1", 32'(bclk_w[0]), 32'h0);
      @(negedge clk);
      chk("start_bclk_c2", 32'(bclk_w[0]), 32'h1);
      wait_count(0, s0 + 1, 600);
      chk("restart_L", 32'(fl[0]), 32'(e_5555));
      chk("restart_R", 32'(fr[0]), 32'(e_aaaa));
      chk("restart_fmt", 32'(fok[0]), 32'h1);
      chk("restart_no_underrun", 32'(upulses[0] - su), 32'h0);

      // long underrun run on lane 1: counter saturates, pulses keep coming
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      strobe(16'h1234, 16'hABCD);
      @(posedge clk);
      s1 = fcount[1];
      su = upulses[1];
      wait_count(1, s1 + 262, 262 * 128 + 1000);
      chk("sat_ucnt", 32'(ucnt_w[1]), 32'd255);
      chk("sat_upulses", 32'(upulses[1] - su), 32'd261);
      chk("sat_replay_L", 32'(fl[1]), 32'(e_sat_l));
      chk("sat_replay_R", 32'(fr[1]), 32'(e_sat_r));
      chk("sat_fmt", 32'(fok[1]), 32'h1);

      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

endmodule
